// File: rtl/mac_rx.sv
// RMII receive MAC for the ncoin link: preamble/SFD hunt, 64-octet frame capture,
// CRC-32 and header checks, then a one-cycle valid or drop strobe per frame.
module mac_rx #(
    parameter logic [0:5][3:0][1:0] LOCAL_MAC      = {8'h2, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0},
    parameter logic [15:0]          NCOIN_ETH_TYPE = 16'hc0de,
    parameter logic                 ACCEPT_BCAST   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             rx_d,
    input  logic                   crs_dv,
    output logic                   valid,
    output logic [127:0]           data,
    output logic [0:5][3:0][1:0]   src_mac,
    output logic                   drop,
    output logic                   crc_err,
    output logic [2:0]             o_dbg_state
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_DATA     = 3'd2,
        S_TAIL     = 3'd3,
        S_CHECK    = 3'd4,
        S_DISCARD  = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_crs_dv_d;
    logic [3:0]            r_pre_cnt;
    logic [7:0]            r_dib_cnt;
    logic [31:0]           r_crc;
    logic                  r_oversize;
    logic [0:31][3:0][1:0] r_frame;
    logic                  r_valid;
    logic                  r_drop;
    logic                  r_crc_err;
    logic [127:0]          r_data;
    logic [0:5][3:0][1:0]  r_src_mac;

    logic                  w_pre_clr;
    logic                  w_pre_inc;
    logic                  w_start;
    logic                  w_take;
    logic                  w_set_over;
    logic                  w_runt;
    logic                  w_check;
    logic                  w_rise;

    logic [0:5][3:0][1:0]  w_dst;
    logic [0:5][3:0][1:0]  w_src;
    logic [15:0]           w_etype;
    logic [127:0]          w_hash;
    logic                  w_crc_good;
    logic                  w_dst_ok;
    logic                  w_accept;

    // Reflected CRC-32, two wire bits per call, bit 0 first.
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] x;
        x = c;
        for (int i = 0; i < 2; i++) begin
            x = (x >> 1) ^ (((x[0] ^ d[i]) != 1'b0) ? CRC_POLY : 32'h0);
        end
        return x;
    endfunction

    assign w_rise = crs_dv & ~r_crs_dv_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pre_clr    = 1'b0;
        w_pre_inc    = 1'b0;
        w_start      = 1'b0;
        w_take       = 1'b0;
        w_set_over   = 1'b0;
        w_runt       = 1'b0;
        w_check      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_next_state = S_PREAMBLE;
                    w_pre_clr    = 1'b1;
                end
            end
            S_PREAMBLE: begin
                if (!crs_dv) begin
                    w_next_state = S_IDLE;
                end else begin
                    case (rx_d)
                        2'b01: w_pre_inc = 1'b1;
                        2'b00: ;
                        2'b11: begin
                            if (r_pre_cnt >= 4'd4) begin
                                w_next_state = S_DATA;
                                w_start      = 1'b1;
                            end else begin
                                w_next_state = S_DISCARD;
                            end
                        end
                        default: w_next_state = S_DISCARD;
                    endcase
                end
            end
            S_DATA: begin
                if (crs_dv) begin
                    w_take = 1'b1;
                    if (r_dib_cnt == 8'hFF) begin
                        w_next_state = S_TAIL;
                    end
                end else begin
                    w_runt       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_TAIL: begin
                if (crs_dv) begin
                    w_set_over = 1'b1;
                end else begin
                    w_next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                // A 1-cycle IFG puts the next frame's rising crs_dv here.
                w_check = 1'b1;
                if (w_rise) begin
                    w_next_state = S_PREAMBLE;
                    w_pre_clr    = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (!crs_dv) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_dst   = '0;
        w_src   = '0;
        w_hash  = '0;
        for (int i = 0; i < 6; i++) begin
            w_dst[i] = r_frame[i];
            w_src[i] = r_frame[6 + i];
        end
        for (int i = 0; i < 16; i++) begin
            w_hash[8*i +: 8] = r_frame[16 + i];
        end
        w_etype    = {r_frame[12], r_frame[13]};
        w_crc_good = (r_crc == CRC_RESIDUE);
        w_dst_ok   = (w_dst == LOCAL_MAC) || (ACCEPT_BCAST && (w_dst == '1));
        w_accept   = w_crc_good && !r_oversize && w_dst_ok &&
                     (w_etype == NCOIN_ETH_TYPE) &&
                     (r_frame[14] == 8'h01) && (r_frame[15] == 8'h01);
    end

    // Only octets 0-31 are kept; padding and FCS only feed the CRC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_crs_dv_d <= 1'b1;
            r_pre_cnt  <= '0;
            r_dib_cnt  <= '0;
            r_crc      <= '0;
            r_oversize <= 1'b0;
            r_frame    <= '0;
            r_valid    <= 1'b0;
            r_drop     <= 1'b0;
            r_crc_err  <= 1'b0;
            r_data     <= '0;
            r_src_mac  <= '0;
        end else begin
            r_crs_dv_d <= crs_dv;

            if (w_pre_clr) begin
                r_pre_cnt <= '0;
            end else if (w_pre_inc && (r_pre_cnt != 4'hF)) begin
                r_pre_cnt <= r_pre_cnt + 4'd1;
            end

            if (w_start) begin
                r_dib_cnt  <= '0;
                r_crc      <= 32'hFFFFFFFF;
                r_oversize <= 1'b0;
            end else if (w_take) begin
                r_dib_cnt <= r_dib_cnt + 8'd1;
                r_crc     <= crc_dibit(r_crc, rx_d);
                if (!r_dib_cnt[7]) begin
                    r_frame[r_dib_cnt[6:2]][r_dib_cnt[1:0]] <= rx_d;
                end
            end

            if (w_set_over) begin
                r_oversize <= 1'b1;
            end

            r_valid   <= w_check & w_accept;
            r_drop    <= w_runt | (w_check & ~w_accept);
            r_crc_err <= w_check & ~w_crc_good;

            if (w_check && w_accept) begin
                r_data    <= w_hash;
                r_src_mac <= w_src;
            end
        end
    end

    assign valid       = r_valid;
    assign drop        = r_drop;
    assign crc_err     = r_crc_err;
    assign data        = r_data;
    assign src_mac     = r_src_mac;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mac_rx.sv
// Bench for mac_rx: a byte-level transmitter model drives RMII dibits, a frame-level
// reference predicts each strobe into a queue, and a monitor checks strobes as they occur.
module tb_mac_rx;

    localparam logic [31:0]  POLY  = 32'hEDB88320;
    localparam logic [47:0]  LOCAL = 48'h020000000000;
    localparam logic [47:0]  BCAST = 48'hffffffffffff;
    localparam logic [47:0]  SRC1  = 48'h020000000001;
    localparam logic [127:0] HASH1 = 128'h0123456789abcdef0123456789abcdef;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [1:0]           rx_d = 2'b00;
    logic                 crs_dv = 1'b0;
    logic                 valid;
    logic [127:0]         data;
    logic [0:5][3:0][1:0] src_mac;
    logic                 drop;
    logic                 crc_err;
    logic [2:0]           o_dbg_state;

    mac_rx dut (
        .clk        (clk),
        .rst        (rst),
        .rx_d       (rx_d),
        .crs_dv     (crs_dv),
        .valid      (valid),
        .data       (data),
        .src_mac    (src_mac),
        .drop       (drop),
        .crc_err    (crc_err),
        .o_dbg_state(o_dbg_state)
    );

    always #10 clk = ~clk;

    // Expected entry: {valid,drop,crc_err}, src_mac, data.
    logic [178:0] exp_q[$];
    logic [178:0] m_e;
    logic [7:0]   fr[0:64];
    logic [127:0] m_data = '0;
    logic [47:0]  m_src  = '0;
    int           n_vec  = 0;
    int           n_err  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc32_ref();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) begin
            for (int b = 0; b < 8; b++) begin
                if ((c[0] ^ fr[i][b]) == 1'b1) c = (c >> 1) ^ POLY;
                else                           c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic build_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                               input logic [7:0] ver, input logic [7:0] typ, input logic [127:0] hash);
        logic [31:0] fcs;
        for (int i = 0; i < 6; i++) begin
            fr[i]     = dst[47-8*i -: 8];
            fr[6 + i] = src[47-8*i -: 8];
        end
        fr[12] = et[15:8];
        fr[13] = et[7:0];
        fr[14] = ver;
        fr[15] = typ;
        for (int i = 0; i < 16; i++) fr[16 + i] = hash[8*i +: 8];
        for (int i = 32; i < 60; i++) fr[i] = 8'($urandom);
        fr[64] = 8'($urandom);
        fcs = crc32_ref();
        for (int i = 0; i < 4; i++) fr[60 + i] = fcs[8*i +: 8];
    endtask

    // Predicts the DUT's reaction to the frame in fr[] sent with n_oct octets.
    task automatic expect_frame(input int n_oct);
        logic [47:0]  dst;
        logic [47:0]  src;
        logic [127:0] hash;
        logic [2:0]   kind;
        logic         crc_ok;
        logic         hdr_ok;
        for (int i = 0; i < 6; i++) begin
            dst[47-8*i -: 8] = fr[i];
            src[47-8*i -: 8] = fr[6 + i];
        end
        for (int i = 0; i < 16; i++) hash[8*i +: 8] = fr[16 + i];
        crc_ok = (crc32_ref() == {fr[63], fr[62], fr[61], fr[60]});
        hdr_ok = ((dst == LOCAL) || (dst == BCAST)) && ({fr[12], fr[13]} == 16'hc0de) &&
                 (fr[14] == 8'h01) && (fr[15] == 8'h01);
        if (n_oct < 64)       kind = 3'b010;
        else if (!crc_ok)     kind = 3'b011;
        else if (n_oct > 64)  kind = 3'b010;
        else if (hdr_ok) begin
            kind   = 3'b100;
            m_data = hash;
            m_src  = src;
        end else              kind = 3'b010;
        exp_q.push_back({kind, m_src, m_data});
    endtask

    task automatic drive(input logic dv, input logic [1:0] d, input logic r);
        @(negedge clk);
        crs_dv = dv;
        rx_d   = d;
        rst    = r;
    endtask

    // n_pre preamble dibits, SFD, n_oct octets LS dibit first, gap idle cycles.
    // rst_at >= 0 pulses reset for two cycles at the start of that octet.
    task automatic send_frame(input int n_pre, input int n_oct, input int gap, input int rst_at);
        for (int i = 0; i < n_pre; i++) drive(1'b1, 2'b01, 1'b1);
        drive(1'b1, 2'b11, 1'b1);
        for (int o = 0; o < n_oct; o++) begin
            for (int k = 0; k < 4; k++) begin
                drive(1'b1, fr[o][2*k +: 2], !((o == rst_at) && (k < 2)));
            end
        end
        for (int g = 0; g < gap; g++) drive(1'b0, 2'b00, 1'b1);
    endtask

    task automatic good_frame(input int gap);
        build_frame((($urandom & 1) != 0) ? LOCAL : BCAST, {16'h0200, 32'($urandom)}, 16'hc0de,
                    8'h01, 8'h01, {$urandom, $urandom, $urandom, $urandom});
        expect_frame(64);
        send_frame(7, 64, gap, -1);
    endtask

    always @(negedge clk) begin
        if (rst && (valid || drop || crc_err)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_strobe: got valid=%b drop=%b crc_err=%b expected none",
                         valid, drop, crc_err);
            end else begin
                m_e = exp_q.pop_front();
                chk("strobe_kind", {125'd0, valid, drop, crc_err}, {125'd0, m_e[178:176]});
                chk("data", data, m_e[127:0]);
                chk("src_mac", {80'd0, src_mac}, {80'd0, m_e[175:128]});
            end
        end
    end

    initial begin
        int sel;
        int n;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_valid", {127'd0, valid}, 128'd0);
        chk("rst_drop", {127'd0, drop}, 128'd0);
        chk("rst_crc_err", {127'd0, crc_err}, 128'd0);
        chk("rst_data", data, 128'd0);
        chk("rst_src_mac", {80'd0, src_mac}, 128'd0);
        chk("rst_state", {125'd0, o_dbg_state}, 128'd0);
        drive(1'b0, 2'b00, 1'b1);
        repeat (3) drive(1'b0, 2'b00, 1'b1);

        // Directed: good frame, FCS flip, foreign dst, broadcast, bad header fields.
        build_frame(LOCAL, SRC1, 16'hc0de, 8'h01, 8'h01, HASH1);
        expect_frame(64); send_frame(7, 64, 4, -1);
        fr[60] = fr[60] ^ 8'h01;
        expect_frame(64); send_frame(7, 64, 4, -1);
        build_frame(48'h020000000005, SRC1, 16'hc0de, 8'h01, 8'h01, ~HASH1);
        expect_frame(64); send_frame(7, 64, 4, -1);
        build_frame(BCAST, 48'h0200000000aa, 16'hc0de, 8'h01, 8'h01, ~HASH1);
        expect_frame(64); send_frame(7, 64, 4, -1);
        build_frame(LOCAL, SRC1, 16'h0800, 8'h01, 8'h01, HASH1);
        expect_frame(64); send_frame(7, 64, 4, -1);
        build_frame(LOCAL, SRC1, 16'hc0de, 8'h02, 8'h01, HASH1);
        expect_frame(64); send_frame(7, 64, 4, -1);
        build_frame(LOCAL, SRC1, 16'hc0de, 8'h01, 8'h00, HASH1);
        expect_frame(64); send_frame(7, 64, 4, -1);

        // Runt and oversize.
        build_frame(LOCAL, SRC1, 16'hc0de, 8'h01, 8'h01, HASH1);
        expect_frame(40); send_frame(7, 40, 4, -1);
        chk("runt_state_idle", {125'd0, o_dbg_state}, 128'd0);
        expect_frame(65); send_frame(7, 65, 4, -1);

        // Preamble length boundary: first dibit is consumed by edge detection.
        send_frame(3, 64, 4, -1);
        expect_frame(64); send_frame(5, 64, 4, -1);

        // Reset mid-frame with crs_dv held, then a good frame after a 1-cycle gap.
        build_frame(LOCAL, 48'h020000000077, 16'hc0de, 8'h01, 8'h01, HASH1 ^ 128'hff);
        send_frame(7, 64, 1, 20);
        m_data = '0;
        m_src  = '0;
        chk("data_after_rst", data, 128'd0);
        chk("src_after_rst", {80'd0, src_mac}, 128'd0);
        build_frame(LOCAL, SRC1, 16'hc0de, 8'h01, 8'h01, HASH1);
        expect_frame(64); send_frame(7, 64, 1, -1);

        // Back-to-back with minimum gap, then loopback of random hashes.
        for (int i = 0; i < 3; i++) good_frame(1);
        for (int i = 0; i < 100; i++) good_frame($urandom_range(1, 6));

        // Random mix of good and faulty frames.
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 5);
            build_frame(LOCAL, {16'h0200, 32'($urandom)}, 16'hc0de, 8'h01, 8'h01,
                        {$urandom, $urandom, $urandom, $urandom});
            n = 64;
            case (sel)
                1: begin
                    build_frame({16'h0200, 32'($urandom)}, SRC1, 16'hc0de, 8'h01, 8'h01, HASH1);
                end
                2: begin
                    n = $urandom_range(60, 63);
                    fr[n] = fr[n] ^ (8'h01 << $urandom_range(0, 7));
                    n = 64;
                end
                3: build_frame(LOCAL, SRC1, 16'hc0de, 8'($urandom_range(2, 255)), 8'h01, HASH1);
                4: n = $urandom_range(1, 63);
                5: n = 65;
                default: ;
            endcase
            expect_frame(n);
            send_frame(7, n, $urandom_range(1, 5), -1);
        end

        for (int i = 0; (i < 2000) && (exp_q.size() != 0); i++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
